mccu_quota_refill: RTL and testbench
====================================

// Module: mccu_quota_refill
// PURPOSE
//  Budget-side counterpart of the MCCU: drives the MCCU quota load interface (quota value + update strobe)
//  and consumes its per-core quota interrupts. Each core gets its budget reloaded periodically, or on an
//  immediate software reload. Exhaustion events are latched as sticky status, masked into one IRQ line,
//  and counted per core as overruns. Sits between the AXI-lite register wrapper and the MCCU.
// PARAMETERS
//  DATA_WIDTH   32  width of quota/budget values (must match MCCU DATA_WIDTH)
//  PERIOD_WIDTH 32  width of per-core replenish period counter
//  OVR_WIDTH    8   width of per-core saturating overrun counter
//  N_CORES      4   number of monitored cores (must match MCCU N_CORES)
// PORTS
//  clk_i              in   1                          clock, all logic on rising edge
//  rst_i              in   1                          reset; one clock, asynchronous, active-high
//  enable_i           in   1                          1: period counters run and periodic reloads fire
//  budget_i           in   [DATA_WIDTH-1:0][0:N_CORES-1]   periodic reload value per core (SW reg)
//  period_i           in   [PERIOD_WIDTH-1:0][0:N_CORES-1] replenish period in cycles; 0 = periodic off
//  sw_update_i        in   1 [0:N_CORES-1]            one-cycle pulse: immediate reload with sw_quota_i
//  sw_quota_i         in   [DATA_WIDTH-1:0][0:N_CORES-1]   value for immediate reload
//  irq_mask_i         in   1 [0:N_CORES-1]            1 = core status contributes to irq_o
//  irq_clear_i        in   1 [0:N_CORES-1]            one-cycle pulse: clear status and overrun count
//  interruption_quota_i in 1 [0:N_CORES-1]            MCCU quota interrupt (level)
//  quota_o            out  [DATA_WIDTH-1:0][0:N_CORES-1]   to MCCU quota_i
//  update_quota_o     out  1 [0:N_CORES-1]            to MCCU update_quota_i, one-cycle pulse
//  exhausted_o        out  1 [0:N_CORES-1]            budget exhausted in current period
//  irq_status_o       out  1 [0:N_CORES-1]            sticky exhaustion status
//  overrun_cnt_o      out  [OVR_WIDTH-1:0][0:N_CORES-1]  periods ended while exhausted, saturating
//  irq_o              out  1                          OR over cores of irq_status_o & irq_mask_i
// BEHAVIOUR
//  - Reset (rst_i=1, async, mid-operation included): all counters, quota_o, update_quota_o, exhausted_o,
//    irq_status_o, overrun_cnt_o, irq_o = 0 immediately; no reload pulse on exit from reset.
//  - Per-core down-counter cnt: while enable_i=1 and period_i!=0, cnt==0 -> periodic reload event,
//    cnt<=period_i-1; else cnt<=cnt-1. enable_i=0: cnt holds. period_i==0: cnt forced 0, no events.
//    First event after reset/enable with cnt=0 fires immediately; period N -> one event every N cycles.
//  - Reload outputs are registered: event in cycle t -> update_quota_o=1 and quota_o=value in cycle t+1,
//    exactly one cycle; quota_o keeps last loaded value afterwards.
//  - sw_update_i in cycle t -> pulse in t+1 with sw_quota_i (sampled at t); cnt restarts at period_i-1.
//    Works with enable_i=0. Simultaneous with periodic event: SW wins, single pulse, sw_quota_i value.
//  - exhausted_o: set when interruption_quota_i=1; cleared in the cycle a reload pulse is issued
//    (set in same cycle wins).
//  - irq_status_o: set when interruption_quota_i=1; cleared only by irq_clear_i; set wins over clear.
//  - overrun_cnt_o: +1 on each reload event (periodic or SW) when exhausted_o=1; saturates at
//    2^OVR_WIDTH-1, no wrap; irq_clear_i zeroes it and takes priority over same-cycle increment.
//  - irq_o combinational from registered status and irq_mask_i.
//  - Arithmetic unsigned; period_i/budget_i changes take effect at next reload (cnt not retimed).
// STRUCTURE
//  - mccu_pkg: DATA_WIDTH/N_CORES defaults shared with MCCU, reload-source enum {RLD_NONE,RLD_PERIOD,RLD_SW}.
//  - Sub-module mccu_refill_chan: one core's counter, reload mux/register, status and overrun logic;
//    top instantiates N_CORES copies via generate and forms irq_o.
// TESTING
//  - period=5, budget=100, enable=1: update_quota_o pulses every 5 cycles, quota_o=100 on each pulse.
//  - sw_update with sw_quota=7 in same cycle as periodic expiry: single pulse, quota_o=7, next periodic
//    pulse 5 cycles later.
//  - interruption_quota_i high 1 cycle, mask=1: irq_status=1, irq_o=1, exhausted=1; next reload clears
//    exhausted, overrun_cnt=1; irq_clear -> status=0, cnt=0, irq_o=0; clear+interrupt same cycle -> status=1.
//  - Hold exhausted over 300 periods, OVR_WIDTH=8: overrun_cnt_o saturates at 255.
//  - rst_i asserted between counter reload and pulse: all outputs 0 same cycle, no pulse after release.
//  - period=0 or enable=0: no periodic pulses for 50 cycles; sw_update still produces one pulse.

Source files
------------

// File: rtl/mccu_quota_refill_pkg.sv
// rtl/mccu_quota_refill_pkg.sv - shared widths and reload-source encoding for the quota refill block
package mccu_quota_refill_pkg;

    // Defaults shared with the MCCU instance this block feeds
    localparam int DATA_WIDTH_DEF   = 32;
    localparam int PERIOD_WIDTH_DEF = 32;
    localparam int OVR_WIDTH_DEF    = 8;
    localparam int N_CORES_DEF      = 4;

    // Which source produced this cycle's reload, if any
    typedef enum logic [1:0] {
        RLD_NONE   = 2'd0,
        RLD_PERIOD = 2'd1,
        RLD_SW     = 2'd2
    } rld_src_e;

endpackage

// File: rtl/mccu_quota_refill_if.sv
// rtl/mccu_quota_refill_if.sv - quota load / quota interrupt link between refill block and MCCU
interface mccu_quota_refill_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CORES    = 4
);
    logic [DATA_WIDTH-1:0] quota              [0:N_CORES-1];
    logic                  update_quota       [0:N_CORES-1];
    logic                  interruption_quota [0:N_CORES-1];

    // Refill side: loads quotas, receives exhaustion interrupts
    modport master (
        output quota,
        output update_quota,
        input  interruption_quota
    );

    // MCCU side
    modport slave (
        input  quota,
        input  update_quota,
        output interruption_quota
    );
endinterface

// File: rtl/mccu_quota_refill_chan.sv
// rtl/mccu_quota_refill_chan.sv - one core's replenish counter, reload register, status and overrun logic
module mccu_quota_refill_chan
    import mccu_quota_refill_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int OVR_WIDTH    = OVR_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [DATA_WIDTH-1:0]   budget_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    sw_update_i,
    input  logic [DATA_WIDTH-1:0]   sw_quota_i,
    input  logic                    irq_clear_i,
    input  logic                    interruption_quota_i,
    output logic [DATA_WIDTH-1:0]   quota_o,
    output logic                    update_quota_o,
    output logic                    exhausted_o,
    output logic                    irq_status_o,
    output logic [OVR_WIDTH-1:0]    overrun_cnt_o
);

    localparam logic [OVR_WIDTH-1:0] OVR_MAX = '1;

    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]   r_quota;
    logic                    r_update;
    logic                    r_exh;
    logic                    r_status;
    logic [OVR_WIDTH-1:0]    r_ovr;

    logic     w_period_off;
    logic     w_period_hit;
    logic     w_reload;
    rld_src_e w_src;

    assign w_period_off = (period_i == '0);
    assign w_period_hit = enable_i && !w_period_off && (r_cnt == '0);
    assign w_reload     = (w_src != RLD_NONE);

    // Pick the reload source; a software reload hides a coincident periodic one
    always_comb begin
        w_src = RLD_NONE;
        if (sw_update_i) begin
            w_src = RLD_SW;
        end else if (w_period_hit) begin
            w_src = RLD_PERIOD;
        end
    end

    // Replenish down-counter; any reload restarts the period, disable freezes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_period_off) begin
            r_cnt <= '0;
        end else if (w_reload) begin
            r_cnt <= period_i - 1'b1;
        end else if (enable_i) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Registered one-cycle load pulse; quota holds its last loaded value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_update <= 1'b0;
            r_quota  <= '0;
        end else begin
            r_update <= w_reload;
            if (w_reload) begin
                r_quota <= (w_src == RLD_SW) ? sw_quota_i : budget_i;
            end
        end
    end

    // Exhausted for the current period: new interrupt beats the reload that clears it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exh <= 1'b0;
        end else if (interruption_quota_i) begin
            r_exh <= 1'b1;
        end else if (w_reload) begin
            r_exh <= 1'b0;
        end
    end

    // Sticky status, only software clears it and a same-cycle interrupt keeps it set
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_status <= 1'b0;
        end else if (interruption_quota_i) begin
            r_status <= 1'b1;
        end else if (irq_clear_i) begin
            r_status <= 1'b0;
        end
    end

    // Saturating count of periods that ended while still exhausted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovr <= '0;
        end else if (irq_clear_i) begin
            r_ovr <= '0;
        end else if (w_reload && r_exh && (r_ovr != OVR_MAX)) begin
            r_ovr <= r_ovr + 1'b1;
        end
    end

    assign quota_o        = r_quota;
    assign update_quota_o = r_update;
    assign exhausted_o    = r_exh;
    assign irq_status_o   = r_status;
    assign overrun_cnt_o  = r_ovr;

endmodule

// File: rtl/mccu_quota_refill.sv
// rtl/mccu_quota_refill.sv - per-core periodic/software quota reload for the MCCU with masked exhaustion IRQ
module mccu_quota_refill
    import mccu_quota_refill_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int OVR_WIDTH    = OVR_WIDTH_DEF,
    parameter int N_CORES      = N_CORES_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [DATA_WIDTH-1:0]   budget_i      [0:N_CORES-1],
    input  logic [PERIOD_WIDTH-1:0] period_i      [0:N_CORES-1],
    input  logic                    sw_update_i   [0:N_CORES-1],
    input  logic [DATA_WIDTH-1:0]   sw_quota_i    [0:N_CORES-1],
    input  logic                    irq_mask_i    [0:N_CORES-1],
    input  logic                    irq_clear_i   [0:N_CORES-1],
    output logic                    exhausted_o   [0:N_CORES-1],
    output logic                    irq_status_o  [0:N_CORES-1],
    output logic [OVR_WIDTH-1:0]    overrun_cnt_o [0:N_CORES-1],
    output logic                    irq_o,
    mccu_quota_refill_if.master     mccu
);

    logic w_status [0:N_CORES-1];

    for (genvar g = 0; g < N_CORES; g++) begin : g_chan
        mccu_quota_refill_chan #(
            .DATA_WIDTH   (DATA_WIDTH),
            .PERIOD_WIDTH (PERIOD_WIDTH),
            .OVR_WIDTH    (OVR_WIDTH)
        ) u_chan (
            .clk_i                (clk_i),
            .rst_i                (rst_i),
            .enable_i             (enable_i),
            .budget_i             (budget_i[g]),
            .period_i             (period_i[g]),
            .sw_update_i          (sw_update_i[g]),
            .sw_quota_i           (sw_quota_i[g]),
            .irq_clear_i          (irq_clear_i[g]),
            .interruption_quota_i (mccu.interruption_quota[g]),
            .quota_o              (mccu.quota[g]),
            .update_quota_o       (mccu.update_quota[g]),
            .exhausted_o          (exhausted_o[g]),
            .irq_status_o         (w_status[g]),
            .overrun_cnt_o        (overrun_cnt_o[g])
        );
        assign irq_status_o[g] = w_status[g];
    end

    // Single interrupt line from the registered status of unmasked cores
    always_comb begin
        irq_o = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            irq_o = irq_o | (w_status[i] & irq_mask_i[i]);
        end
    end

endmodule

// File: tb/tb_mccu_quota_refill.sv
// tb/tb_mccu_quota_refill.sv - directed table-driven bench for mccu_quota_refill
module tb_mccu_quota_refill;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int OW = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] budget    [0:NC-1];
    logic [PW-1:0] period    [0:NC-1];
    logic          sw_update [0:NC-1];
    logic [DW-1:0] sw_quota  [0:NC-1];
    logic          irq_mask  [0:NC-1];
    logic          irq_clear [0:NC-1];
    logic          exhausted [0:NC-1];
    logic          status    [0:NC-1];
    logic [OW-1:0] ovr       [0:NC-1];
    logic          irq;

    int total = 0;
    int bad   = 0;

    mccu_quota_refill_if #(.DATA_WIDTH(DW), .N_CORES(NC)) mccu_if ();

    mccu_quota_refill #(
        .DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .OVR_WIDTH(OW), .N_CORES(NC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .budget_i      (budget),
        .period_i      (period),
        .sw_update_i   (sw_update),
        .sw_quota_i    (sw_quota),
        .irq_mask_i    (irq_mask),
        .irq_clear_i   (irq_clear),
        .exhausted_o   (exhausted),
        .irq_status_o  (status),
        .overrun_cnt_o (ovr),
        .irq_o         (irq),
        .mccu          (mccu_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sw;
        logic [DW-1:0] swq;
        logic          intr;
        logic          clr;
        logic          e_upd;
        logic [DW-1:0] e_q;
        logic          e_exh;
        logic          e_st;
        logic [OW-1:0] e_ovr;
        logic          e_irq;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_core_zero(input string tag, input int c);
        chk({tag, "_upd"},  32'(mccu_if.update_quota[c]), 32'd0);
        chk({tag, "_q"},    32'(mccu_if.quota[c]),        32'd0);
        chk({tag, "_exh"},  32'(exhausted[c]),            32'd0);
        chk({tag, "_st"},   32'(status[c]),               32'd0);
        chk({tag, "_ovr"},  32'(ovr[c]),                  32'd0);
    endtask

    initial begin
        int pulses;
        int pulses1;
        int waited;

        // core-0 script: period 5, budget 100, irq mask on
        vecs[0]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b1, 32'd100, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'd0, 1'b1, 1'b0,  1'b0, 32'd100, 1'b1, 1'b1, 8'd0, 1'b1};
        vecs[2]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b1, 1'b1, 8'd0, 1'b1};
        vecs[3]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b1, 1'b1, 8'd0, 1'b1};
        vecs[4]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b1, 1'b1, 8'd0, 1'b1};
        vecs[5]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b1, 32'd100, 1'b0, 1'b1, 8'd1, 1'b1};
        vecs[6]  = '{1'b0, 32'd0, 1'b0, 1'b1,  1'b0, 32'd100, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[7]  = '{1'b1, 32'd7, 1'b0, 1'b0,  1'b1, 32'd7,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd7,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd7,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd7,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd7,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[12] = '{1'b1, 32'd9, 1'b0, 1'b0,  1'b1, 32'd9,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[13] = '{1'b0, 32'd0, 1'b1, 1'b1,  1'b0, 32'd9,   1'b1, 1'b1, 8'd0, 1'b1};
        vecs[14] = '{1'b0, 32'd0, 1'b0, 1'b1,  1'b0, 32'd9,   1'b1, 1'b0, 8'd0, 1'b0};
        vecs[15] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd9,   1'b1, 1'b0, 8'd0, 1'b0};
        vecs[16] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd9,   1'b1, 1'b0, 8'd0, 1'b0};
        vecs[17] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b1, 32'd100, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[18] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[19] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[20] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[21] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[22] = '{1'b0, 32'd0, 1'b1, 1'b0,  1'b1, 32'd100, 1'b1, 1'b1, 8'd1, 1'b1};
        vecs[23] = '{1'b0, 32'd0, 1'b0, 1'b0,  1'b0, 32'd100, 1'b1, 1'b1, 8'd1, 1'b1};

        rst    = 1'b1;
        enable = 1'b0;
        for (int c = 0; c < NC; c++) begin
            budget[c]    = '0;
            period[c]    = '0;
            sw_update[c] = 1'b0;
            sw_quota[c]  = '0;
            irq_mask[c]  = 1'b0;
            irq_clear[c] = 1'b0;
            mccu_if.interruption_quota[c] = 1'b0;
        end
        #1;
        chk_core_zero("reset_c0", 0);
        chk("reset_irq", 32'(irq), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_core_zero("post_reset_c0", 0);

        // Table run on core 0; core 1 stays at period 0 and must stay silent
        budget[0]   = 32'd100;
        period[0]   = 32'd5;
        irq_mask[0] = 1'b1;
        budget[1]   = 32'd33;
        enable      = 1'b1;
        pulses1     = 0;
        for (int i = 0; i < 24; i++) begin
            sw_update[0]                  = vecs[i].sw;
            sw_quota[0]                   = vecs[i].swq;
            mccu_if.interruption_quota[0] = vecs[i].intr;
            irq_clear[0]                  = vecs[i].clr;
            tick();
            sw_update[0]                  = 1'b0;
            mccu_if.interruption_quota[0] = 1'b0;
            irq_clear[0]                  = 1'b0;
            if (mccu_if.update_quota[1]) pulses1++;
            chk($sformatf("v%0d_upd", i), 32'(mccu_if.update_quota[0]), 32'(vecs[i].e_upd));
            if (vecs[i].e_upd)
                chk($sformatf("v%0d_quota", i), mccu_if.quota[0], vecs[i].e_q);
            chk($sformatf("v%0d_exh", i), 32'(exhausted[0]), 32'(vecs[i].e_exh));
            chk($sformatf("v%0d_status", i), 32'(status[0]), 32'(vecs[i].e_st));
            chk($sformatf("v%0d_ovr", i), 32'(ovr[0]), 32'(vecs[i].e_ovr));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
        end
        chk("period0_core1_pulses", 32'(pulses1), 32'd0);

        // Mask gates the IRQ line combinationally while status stays set
        irq_mask[0] = 1'b0;
        #1;
        chk("mask_off_irq", 32'(irq), 32'd0);
        chk("mask_off_status", 32'(status[0]), 32'd1);
        irq_mask[0] = 1'b1;
        #1;
        chk("mask_on_irq", 32'(irq), 32'd1);
        tick();

        // Overrun saturation: core 2 reloads every cycle while held exhausted
        period[2] = 32'd1;
        mccu_if.interruption_quota[2] = 1'b1;
        for (int n = 0; n < 100; n++) tick();
        chk("ovr_after_100", 32'(ovr[2]), 32'd99);
        for (int n = 0; n < 200; n++) tick();
        chk("ovr_saturated", 32'(ovr[2]), 32'd255);
        tick();
        chk("ovr_no_wrap", 32'(ovr[2]), 32'd255);
        mccu_if.interruption_quota[2] = 1'b0;
        period[2]    = '0;
        irq_clear[2] = 1'b1;
        tick();
        irq_clear[2] = 1'b0;
        chk("ovr_cleared", 32'(ovr[2]), 32'd0);
        chk("status2_cleared", 32'(status[2]), 32'd0);

        // Disabled: no periodic pulses for 50 cycles, SW reload still works
        enable = 1'b0;
        tick();
        pulses = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (mccu_if.update_quota[0]) pulses++;
        end
        chk("disabled_pulses", 32'(pulses), 32'd0);
        sw_update[0] = 1'b1;
        sw_quota[0]  = 32'd55;
        sw_update[1] = 1'b1;
        sw_quota[1]  = 32'd66;
        tick();
        sw_update[0] = 1'b0;
        sw_update[1] = 1'b0;
        chk("disabled_sw_upd", 32'(mccu_if.update_quota[0]), 32'd1);
        chk("disabled_sw_quota", mccu_if.quota[0], 32'd55);
        chk("period0_sw_upd", 32'(mccu_if.update_quota[1]), 32'd1);
        chk("period0_sw_quota", mccu_if.quota[1], 32'd66);
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (mccu_if.update_quota[0] || mccu_if.update_quota[1]) pulses++;
        end
        chk("sw_single_pulse", 32'(pulses), 32'd0);

        // Async reset while a pulse is on the bus
        enable = 1'b1;
        waited = 0;
        while (!mccu_if.update_quota[0] && waited < 20) begin
            tick();
            waited++;
        end
        chk("reset_wait_pulse", 32'(mccu_if.update_quota[0]), 32'd1);
        mccu_if.interruption_quota[0] = 1'b1;
        tick();
        mccu_if.interruption_quota[0] = 1'b0;
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        chk_core_zero("async_reset_c0", 0);
        chk("async_reset_irq", 32'(irq), 32'd0);
        #3;
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (mccu_if.update_quota[0]) pulses++;
        end
        chk("no_pulse_after_reset", 32'(pulses), 32'd0);
        chk("quota_after_reset", mccu_if.quota[0], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
